// File: rtl/cmd_decoder_pkg.sv
// cmd_decoder_pkg: opcode constants and FSM state encoding shared by the command decoder
package cmd_decoder_pkg;
    localparam logic [3:0] OP_CLEAR          = 4'd0;
    localparam logic [3:0] OP_SET_INDEX      = 4'd1;
    localparam logic [3:0] OP_SET_LEDS       = 4'd2;
    localparam logic [3:0] OP_SET_BAUD_RATE  = 4'd3;
    localparam logic [3:0] OP_SET_DELAY      = 4'd4;
    localparam logic [3:0] OP_ENABLE_CAPTURE = 4'd13;
    typedef enum logic {S_IDLE, S_COLLECT} state_t;
endpackage

// File: rtl/cmd_decoder.sv
// cmd_decoder: UART command bytes to index, LED, baud, capture and per-channel delay registers
module cmd_decoder
    import cmd_decoder_pkg::*;
#(
    parameter int NUM_INPUTS     = 4,
    parameter int DELAY_WIDTH    = 20,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic [3:0]                        index,
    output logic [31:0]                       leds,
    output logic [3:0]                        baud_rate,
    output logic                              capture_enable,
    output logic [NUM_INPUTS*DELAY_WIDTH-1:0] delay_flat,
    output logic                              delay_update,
    output logic                              cmd_error
);
    localparam int NIB = DELAY_WIDTH / 4;
    localparam int PW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] LAST = PW'(NIB - 1);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);
    state_t state;
    logic [PW-1:0] ptr;
    logic [DELAY_WIDTH-1:0] shadow, filled;
    logic [CW-1:0] idle_cnt;
    logic [3:0] op, arg;
    logic idx_ok;
    assign op = rx_data[3:0];
    assign arg = rx_data[7:4];
    assign idx_ok = int'(index) < NUM_INPUTS;
    always_comb begin
        filled = shadow;
        filled[ptr*4 +: 4] = arg;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            ptr            <= '0;
            shadow         <= '0;
            idle_cnt       <= '0;
            index          <= '0;
            leds           <= '0;
            baud_rate      <= '0;
            capture_enable <= 1'b0;
            delay_flat     <= '0;
            delay_update   <= 1'b0;
            cmd_error      <= 1'b0;
        end else begin
            delay_update <= 1'b0;
            cmd_error    <= 1'b0;
            idle_cnt     <= '0;
            if (rx_valid) begin
                case (op)
                    OP_CLEAR: begin
                        state  <= S_IDLE;
                        ptr    <= '0;
                        shadow <= '0;
                    end
                    OP_SET_INDEX: begin
                        index <= arg;
                        if (state == S_COLLECT) begin
                            state     <= S_IDLE;
                            ptr       <= '0;
                            cmd_error <= 1'b1;
                        end
                    end
                    OP_SET_LEDS:       leds[index*2 +: 2] <= rx_data[5:4];
                    OP_SET_BAUD_RATE:  baud_rate <= arg;
                    OP_ENABLE_CAPTURE: capture_enable <= rx_data[4];
                    OP_SET_DELAY: begin
                        if (!idx_ok) begin
                            state     <= S_IDLE;
                            ptr       <= '0;
                            cmd_error <= 1'b1;
                        end else if (state == S_IDLE) begin
                            shadow[3:0] <= arg;
                            ptr         <= PW'(1);
                            state       <= S_COLLECT;
                        end else if (ptr == LAST) begin
                            delay_flat[index*DELAY_WIDTH +: DELAY_WIDTH] <= filled;
                            delay_update <= 1'b1;
                            ptr          <= '0;
                            state        <= S_IDLE;
                        end else begin
                            shadow <= filled;
                            ptr    <= ptr + 1'b1;
                        end
                    end
                    default: cmd_error <= 1'b1;
                endcase
            end else if (state == S_COLLECT) begin
                // a stalled load is dropped once the link has been silent too long
                if (idle_cnt == TLIM) begin
                    state     <= S_IDLE;
                    ptr       <= '0;
                    cmd_error <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed byte streams checked every cycle against a queue-based command model
module tb_cmd_decoder;
    localparam int NI = 4;
    localparam int DW = 20;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic [3:0] index;
    logic [31:0] leds;
    logic [3:0] baud_rate;
    logic capture_enable;
    logic [NI*DW-1:0] delay_flat;
    logic delay_update;
    logic cmd_error;
    int checks = 0;
    int errors = 0;
    int n_upd = 0;
    int n_err = 0;
    logic [3:0] m_index;
    logic [31:0] m_leds;
    logic [3:0] m_baud;
    logic m_cap, m_upd, m_err;
    logic [DW-1:0] m_delay [NI];
    logic [3:0] nibs [$];
    int m_idle;

    cmd_decoder #(.NUM_INPUTS(NI), .DELAY_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .index(index), .leds(leds), .baud_rate(baud_rate), .capture_enable(capture_enable),
        .delay_flat(delay_flat), .delay_update(delay_update), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_index = 0; m_leds = 0; m_baud = 0; m_cap = 0; m_upd = 0; m_err = 0; m_idle = 0;
        for (int i = 0; i < NI; i++) m_delay[i] = '0;
        nibs.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        logic [DW-1:0] val;
        m_upd = 0;
        m_err = 0;
        if (v) begin
            m_idle = 0;
            case (int'(d[3:0]))
                0: nibs.delete();
                1: begin
                    if (nibs.size() > 0) begin m_err = 1; nibs.delete(); end
                    m_index = d[7:4];
                end
                2: m_leds = (m_leds & ~(32'h3 << (2 * int'(m_index)))) | (32'(d[5:4]) << (2 * int'(m_index)));
                3: m_baud = d[7:4];
                13: m_cap = d[4];
                4: begin
                    if (int'(m_index) >= NI) begin
                        m_err = 1;
                        nibs.delete();
                    end else begin
                        nibs.push_back(d[7:4]);
                        if (nibs.size() == DW / 4) begin
                            val = '0;
                            foreach (nibs[i]) val = val | (DW'(nibs[i]) << (4 * i));
                            m_delay[m_index] = val;
                            m_upd = 1;
                            nibs.delete();
                        end
                    end
                end
                default: m_err = 1;
            endcase
        end else if (nibs.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_err = 1;
                nibs.delete();
                m_idle = 0;
            end
        end
    endtask

    always @(posedge reset) model_reset();

    always @(posedge clk) begin
        logic [NI*DW-1:0] e;
        if (reset) model_reset();
        else model_step(rx_valid, rx_data);
        #1;
        e = '0;
        for (int i = 0; i < NI; i++) e[i*DW +: DW] = m_delay[i];
        chk("index", 128'(index), 128'(m_index));
        chk("leds", 128'(leds), 128'(m_leds));
        chk("baud_rate", 128'(baud_rate), 128'(m_baud));
        chk("capture_enable", 128'(capture_enable), 128'(m_cap));
        chk("delay_flat", 128'(delay_flat), 128'(e));
        chk("delay_update", 128'(delay_update), 128'(m_upd));
        chk("cmd_error", 128'(cmd_error), 128'(m_err));
        if (delay_update) n_upd++;
        if (cmd_error) n_err++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bs [$]);
        foreach (bs[i]) send(bs[i]);
    endtask

    initial begin
        int u0, e0;
        repeat (2) @(negedge clk);
        chk("reset_all", 128'({index, leds, baud_rate, capture_enable, delay_flat, delay_update, cmd_error}), 128'(0));
        reset = 1'b0;
        e0 = n_err;
        send_list('{8'h71, 8'h14, 8'h24, 8'h34, 8'h44, 8'h54});
        chk("bad_index_errors", 128'(n_err - e0), 128'(5));
        chk("bad_index_no_delay", 128'(delay_flat), 128'(0));
        u0 = n_upd;
        send_list('{8'h21, 8'h14, 8'h24, 8'h34, 8'h44, 8'h54});
        chk("ch2_value", 128'(delay_flat[40 +: 20]), 128'(20'h54321));
        chk("ch2_others", 128'(delay_flat & ~(80'hFFFFF << 40)), 128'(0));
        chk("ch2_one_update", 128'(n_upd - u0), 128'(1));
        send_list('{8'h31, 8'h14, 8'h24, 8'h32, 8'hF3, 8'h34, 8'h44, 8'h54});
        chk("leds_pair3", 128'(leds), 128'(32'hC0));
        chk("baud_f", 128'(baud_rate), 128'(4'hF));
        chk("ch3_value", 128'(delay_flat[60 +: 20]), 128'(20'h54321));
        e0 = n_err; u0 = n_upd;
        send_list('{8'h04, 8'h14, 8'h11});
        chk("abort_by_index_err", 128'(n_err - e0), 128'(1));
        chk("abort_index", 128'(index), 128'(1));
        chk("abort_no_commit", 128'(n_upd - u0), 128'(0));
        send_list('{8'h94, 8'h84, 8'h74, 8'h64, 8'h54});
        chk("ch1_value", 128'(delay_flat[20 +: 20]), 128'(20'h56789));
        e0 = n_err;
        send_list('{8'h01, 8'h14, 8'h24, 8'h00, 8'hA4, 8'hB4, 8'hC4, 8'hD4, 8'hE4});
        chk("clear_restart_ch0", 128'(delay_flat[0 +: 20]), 128'(20'hEDCBA));
        chk("clear_no_error", 128'(n_err - e0), 128'(0));
        e0 = n_err; u0 = n_upd;
        send_list('{8'h04, 8'h14});
        repeat (TO + 6) @(negedge clk);
        chk("timeout_one_error", 128'(n_err - e0), 128'(1));
        send_list('{8'h24, 8'h34, 8'h44, 8'h54});
        chk("timeout_discarded", 128'(n_upd - u0), 128'(0));
        send(8'h04);
        e0 = n_err; u0 = n_upd;
        send_list('{8'h14, 8'h24});
        #2 reset = 1'b1;
        #1 chk("midreset_all", 128'({index, leds, baud_rate, capture_enable, delay_flat, delay_update, cmd_error}), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        send_list('{8'h34, 8'h44, 8'h54});
        chk("midreset_no_pulses", 128'((n_err - e0) + (n_upd - u0)), 128'(0));
        send(8'h04);
        send(8'h1D);
        chk("capture_on", 128'(capture_enable), 128'(1));
        send(8'h0D);
        chk("capture_off", 128'(capture_enable), 128'(0));
        e0 = n_err;
        send(8'h0E);
        chk("bad_opcode_error", 128'(n_err - e0), 128'(1));
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
